// File: rtl/pipelined_controller.sv
// Single-stage instruction decoder with a registered output bundle, valid/ready
// handshaking on both sides, and load-use bubble insertion.
module pipelined_controller #(
  parameter int HAZARD_EN    = 1,
  parameter int STALL_CYCLES = 1,
  parameter int ZERO_REG     = 31
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [31:0] instruction,
  input  logic        inValid,
  output logic        inReady,
  input  logic        flush,
  output logic        outValid,
  input  logic        outReady,
  output logic [2:0]  opType,
  output logic [3:0]  aluControlCode,
  output logic [7:0]  ctrlFlags,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  output logic        hazardStall
);

  typedef enum logic [2:0] {
    OP_LD = 3'd0,
    OP_CB = 3'd1,
    OP_R  = 3'd2,
    OP_ST = 3'd3,
    OP_I  = 3'd4,
    OP_B  = 3'd5,
    OP_M  = 3'd6
  } op_e;

  localparam bit         HAZ_ON     = (HAZARD_EN != 0);
  localparam logic [1:0] STALL_LOAD = STALL_CYCLES[1:0];
  localparam logic [4:0] ZERO_IDX   = ZERO_REG[4:0];

  logic       r_out_valid;
  logic [2:0] r_op;
  logic [3:0] r_alu;
  logic [7:0] r_flags;
  logic [4:0] r_rr1;
  logic [4:0] r_rr2;
  logic [4:0] r_wr;
  logic [1:0] r_stall_cnt;
  logic       r_last_ld_valid;
  logic [4:0] r_last_ld_dst;

  op_e        w_op;
  logic       w_is_ld, w_is_cb, w_is_r, w_is_st, w_is_i, w_is_b, w_is_m;
  logic       w_reg2loc;
  logic [7:0] w_flags;
  logic [3:0] w_alu;
  logic [4:0] w_rr1, w_rr2, w_wr;
  logic       w_uses1, w_uses2;
  logic       w_src_match;
  logic       w_hazard_now;
  logic       w_stall_active;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_unused;

  // Bits that carry no decode or register information for this block.
  assign w_unused = ^{instruction[31], instruction[21], instruction[15:10]};

  always_comb begin
    w_op = OP_I;
    if (instruction[26])       w_op = instruction[29] ? OP_CB : OP_B;
    else if (!instruction[28]) w_op = OP_R;
    else if (instruction[23])  w_op = OP_M;
    else if (instruction[22])  w_op = OP_LD;
    else if (instruction[27])  w_op = OP_ST;
  end

  assign w_is_ld = (w_op == OP_LD);
  assign w_is_cb = (w_op == OP_CB);
  assign w_is_r  = (w_op == OP_R);
  assign w_is_st = (w_op == OP_ST);
  assign w_is_i  = (w_op == OP_I);
  assign w_is_b  = (w_op == OP_B);
  assign w_is_m  = (w_op == OP_M);

  assign w_reg2loc = w_is_cb | w_is_st;
  assign w_flags   = {w_is_b,                           // unconditionalBranch
                      w_is_cb,                          // branch
                      w_is_ld,                          // memRead
                      w_is_ld,                          // memToReg
                      w_is_st,                          // memWrite
                      ~(w_is_r | w_is_cb),              // aluSRC
                      w_is_r | w_is_ld | w_is_m | w_is_i, // regWriteFlag
                      w_reg2loc};                       // reg2Loc

  always_comb begin
    w_alu = 4'd0;
    case (w_op)
      OP_LD, OP_ST: w_alu = 4'd2;
      OP_CB:        w_alu = 4'd7;
      OP_M:         w_alu = 4'd13;
      OP_R: begin
        if (instruction[24])       w_alu = instruction[30] ? 4'd10 : 4'd2;
        else if (!instruction[29]) w_alu = 4'd6;
        else if (!instruction[30]) w_alu = 4'd4;
        else                       w_alu = 4'd9;
      end
      OP_I: begin
        if (instruction[29])      w_alu = 4'd4;
        else if (instruction[30]) w_alu = instruction[25] ? 4'd9 : 4'd10;
        else                      w_alu = instruction[25] ? 4'd6 : 4'd2;
      end
      OP_B:    w_alu = 4'd0;
      default: w_alu = 4'd0;
    endcase
  end

  assign w_rr1 = instruction[9:5];
  assign w_rr2 = w_reg2loc ? instruction[4:0] : instruction[20:16];
  assign w_wr  = instruction[4:0];

  assign w_uses1 = w_is_r | w_is_i | w_is_ld | w_is_st;
  assign w_uses2 = w_is_r | w_is_cb | w_is_st;

  assign w_src_match  = (w_uses1 && (w_rr1 == r_last_ld_dst)) ||
                        (w_uses2 && (w_rr2 == r_last_ld_dst));
  assign w_hazard_now = HAZ_ON && r_last_ld_valid && inValid && w_src_match &&
                        (r_last_ld_dst != ZERO_IDX);

  assign w_stall_active = (r_stall_cnt != 2'd0);
  assign w_in_ready     = !flush && !w_stall_active && !w_hazard_now &&
                          (!r_out_valid || outReady);
  assign w_accept       = inValid && w_in_ready;

  // Field registers only move on an accept; flush deliberately leaves them alone.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_op    <= 3'd0;
      r_alu   <= 4'd0;
      r_flags <= 8'd0;
      r_rr1   <= 5'd0;
      r_rr2   <= 5'd0;
      r_wr    <= 5'd0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_alu   <= w_alu;
      r_flags <= w_flags;
      r_rr1   <= w_rr1;
      r_rr2   <= w_rr2;
      r_wr    <= w_wr;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_out_valid     <= 1'b0;
      r_stall_cnt     <= 2'd0;
      r_last_ld_valid <= 1'b0;
      r_last_ld_dst   <= 5'd0;
    end else if (flush) begin
      r_out_valid     <= 1'b0;
      r_stall_cnt     <= 2'd0;
      r_last_ld_valid <= 1'b0;
    end else begin
      if (w_accept)      r_out_valid <= 1'b1;
      else if (outReady) r_out_valid <= 1'b0;

      if (w_stall_active)    r_stall_cnt <= r_stall_cnt - 2'd1;
      else if (w_hazard_now) r_stall_cnt <= STALL_LOAD;

      // The load result is forwarded once the bubbles drain, so the hazard is retired.
      if (w_accept) begin
        r_last_ld_valid <= w_is_ld;
        if (w_is_ld) r_last_ld_dst <= w_wr;
      end else if (r_stall_cnt == 2'd1) begin
        r_last_ld_valid <= 1'b0;
      end
    end
  end

  assign inReady        = w_in_ready;
  assign outValid       = r_out_valid;
  assign opType         = r_op;
  assign aluControlCode = r_alu;
  assign ctrlFlags      = r_flags;
  assign readRegister1  = r_rr1;
  assign readRegister2  = r_rr2;
  assign writeRegister  = r_wr;
  assign hazardStall    = w_stall_active;

endmodule
